// File: rtl/mux_scan_sel_if.sv
`default_nettype none
// ============================================================================
// Module      : mux_scan_sel_if
// Description : Bus bundle for the registered N-channel scan selector.
//               Channel data, select controls and registered selector status.
// Revision    : 1.0 - initial release
// ============================================================================
interface mux_scan_sel_if #(
  parameter int W    = 4,
  parameter int N    = 4,
  parameter int SELW = 2
) ();

  logic [N*W-1:0]  din;
  logic [SELW-1:0] sel;
  logic            mode;
  logic            hold;
  logic [W-1:0]    dout;
  logic [SELW-1:0] cur_sel;
  logic            sel_chg;
  logic            scan_active;

  // Source side: drives data and controls, observes the selector
  modport master (
    output din, sel, mode, hold,
    input  dout, cur_sel, sel_chg, scan_active
  );

  // Selector side
  modport slave (
    input  din, sel, mode, hold,
    output dout, cur_sel, sel_chg, scan_active
  );

endinterface
`default_nettype wire

// File: rtl/mux_scan_sel.sv
`default_nettype none
// ============================================================================
// Module      : mux_scan_sel
// Description : Registered N-channel, W-bit selector with manual select,
//               round-robin auto-scan with programmable dwell, global hold
//               and a one-cycle select-change strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module mux_scan_sel #(
  parameter int W     = 4,
  parameter int N     = 4,
  parameter int SELW  = 2,
  parameter int DWELL = 50000000
) (
  input  logic          CLOCK_50,
  input  logic          resetn,
  mux_scan_sel_if.slave bus
);

  // Dwell counter only needs to reach DWELL-1; keep at least one bit so
  // DWELL=1 still elaborates (compare is then always true -> advance each cycle).
  localparam int              CW         = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0]   C_CNT_LAST = CW'(DWELL - 1);
  localparam logic [SELW-1:0] C_SEL_LAST = SELW'(N - 1);

  typedef enum logic [0:0] {
    ST_MANUAL = 1'b0,
    ST_SCAN   = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [SELW-1:0] cur_sel_q, nsel_d;
  logic [W-1:0]    dout_q, dout_d;
  logic            sel_chg_q;
  logic            scan_active_q;
  logic            sel_ok;

  // Manual selects at or beyond N are ignored rather than wrapped
  assign sel_ok = (32'(bus.sel) < 32'(N));

  // Next state, dwell count and channel select, plus the data for that channel
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    nsel_d  = cur_sel_q;
    dout_d  = '0;

    case (state_q)
      ST_MANUAL: begin
        if (bus.mode) begin
          // Scan resumes from the current channel; first advance after a full dwell
          state_d = ST_SCAN;
          cnt_d   = '0;
        end else if (sel_ok) begin
          nsel_d = bus.sel;
        end
      end
      ST_SCAN: begin
        if (!bus.mode) begin
          // Leaving scan takes the manual select in the same cycle
          state_d = ST_MANUAL;
          cnt_d   = '0;
          if (sel_ok) begin
            nsel_d = bus.sel;
          end
        end else if (cnt_q == C_CNT_LAST) begin
          cnt_d  = '0;
          nsel_d = (cur_sel_q == C_SEL_LAST) ? '0 : cur_sel_q + SELW'(1);
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = ST_MANUAL;
        cnt_d   = '0;
      end
    endcase

    for (int k = 0; k < N; k++) begin
      if (nsel_d == SELW'(k)) begin
        dout_d = bus.din[k*W +: W];
      end
    end
  end

  // All state and outputs update together; hold freezes everything but the strobe
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_q       <= ST_MANUAL;
      cnt_q         <= '0;
      cur_sel_q     <= '0;
      dout_q        <= '0;
      sel_chg_q     <= 1'b0;
      scan_active_q <= 1'b0;
    end else if (bus.hold) begin
      sel_chg_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      cur_sel_q     <= nsel_d;
      dout_q        <= dout_d;
      sel_chg_q     <= (nsel_d != cur_sel_q);
      scan_active_q <= bus.mode;
    end
  end

  assign bus.dout        = dout_q;
  assign bus.cur_sel     = cur_sel_q;
  assign bus.sel_chg     = sel_chg_q;
  assign bus.scan_active = scan_active_q;

endmodule
`default_nettype wire
